stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo.sv | 74 +++++++
 tb/tb_stream_fifo.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO: circular buffer with registered count,
// full/empty derived from count, and sticky overflow/underflow flags.
module stream_fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] din,
  output logic              full,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int                DEPTH    = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   CNT_FULL = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0]   CNT_ONE  = 1;
  localparam logic [AWIDTH-1:0] PTR_ONE  = 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Flags come from registered count only, so they never depend on this cycle's requests.
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign dout      = mem_q[rd_ptr_q];

  always_comb begin
    wr_acc      = wr_en && !full;
    rd_acc      = rd_en && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  || (wr_en && full);
    underflow_d = underflow_q || (rd_en && empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: stimulus pushes expected words into a
// scoreboard queue, a negedge monitor pops and compares on every accepted read.
module tb_stream_fifo;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din   = '0;
  logic       rd_en = 1'b0;
  logic       full, empty, overflow, underflow;
  logic [7:0] dout;
  logic [4:0] count;

  int         checks = 0;
  int         errors = 0;
  int         m_cnt  = 0;
  logic [7:0] sb_q[$];

  stream_fifo #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(din), .full(full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, pops on every read the DUT will accept.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && rd_en && !empty) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected no data", dout);
        end else begin
          chk("pop_data", {24'd0, dout}, {24'd0, sb_q.pop_front()});
        end
      end
    end
  end

  // Drive one cycle; the bench model decides acceptance from its own count.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    bit wacc, racc;
    wr_en = w; din = d; rd_en = r;
    wacc = w && (m_cnt < DEPTH);
    racc = r && (m_cnt > 0);
    if (wacc) sb_q.push_back(d);
    m_cnt = m_cnt + int'(wacc) - int'(racc);
    @(posedge clock); #1;
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
  endtask

  task automatic do_reset(input logic w);
    reset = 1'b1; wr_en = w; din = 8'h55; rd_en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; wr_en = 1'b0;
    sb_q.delete();
    m_cnt = 0;
  endtask

  initial begin
    #1;
    do_reset(1'b0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // Single word: visible one cycle after write, gone after read.
    step(1'b1, 8'h05, 1'b0);
    chk("w1_empty", empty, 0);
    chk("w1_count", count, 1);
    chk("w1_dout", dout, 8'h05);
    step(1'b0, 8'h00, 1'b1);
    chk("r1_empty", empty, 1);
    chk("r1_count", count, 0);

    // Fill to full, then a rejected write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 0);
    step(1'b1, 8'h3C, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_head", dout, 8'h00);

    // Full with both requests: read wins, 0x7F rejected, 0x00 popped.
    step(1'b1, 8'h7F, 1'b1);
    chk("fb_count", count, 15);
    chk("fb_ovf", overflow, 1);
    chk("fb_full", full, 0);
    for (int i = 1; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_unf", underflow, 0);

    // Empty with both requests: write wins, read flagged.
    step(1'b1, 8'h80, 1'b1);
    chk("eb_count", count, 1);
    chk("eb_dout", dout, 8'h80);
    chk("eb_unf", underflow, 1);
    step(1'b0, 8'h00, 1'b1);

    // Sustained streaming at count=3 across two pointer wraps.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("pre_stream_count", count, 3);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'hB0 + 8'(i), 1'b1);
      if (count != 5'd3) chk("stream_count", count, 3);
    end
    chk("stream_count_end", count, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("stream_drained", empty, 1);

    // Mid-operation reset with a write request pending.
    for (int i = 0; i < 9; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("pre_rst_count", count, 9);
    do_reset(1'b1);
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_unf", underflow, 0);
    step(1'b1, 8'hAA, 1'b0);
    chk("post_rst_dout", dout, 8'hAA);
    chk("post_rst_count", count, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_empty", empty, 1);

    @(negedge clock);
    chk("sb_leftover", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
